// File: rtl/mem1_write_controller.sv
// mem1_write_controller: MEM1 write address/strobe generator for CONV1, CONV2, CONV3 and FCL1 output words
//   iCLK, iRSTn       clock, async active-low reset
//   iEN, iSTATE       sequencer enable and current layer state
//   iVALID, iDATA     serial layer output word
//   oADDR, oDATA, oWE registered MEM1 write port
//   oDONE             one-cycle pulse after the layer's last write has landed
module mem1_write_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM1_OFFSET = 252
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iEN,
  input  logic [2:0]            iSTATE,
  input  logic                  iVALID,
  input  logic [DATA_WIDTH-1:0] iDATA,
  output logic [8:0]            oADDR,
  output logic [DATA_WIDTH-1:0] oDATA,
  output logic                  oWE,
  output logic                  oDONE
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
  state_t state, nState;
  logic [2:0] stQ, nStQ;
  logic [8:0] base, nBase, count, nCount, cnt, nCnt, nAddr, mapBase, mapCount;
  logic [DATA_WIDTH-1:0] nData;
  logic isWr, accept, nWe, donePend, nDonePend;
  assign isWr = iSTATE >= 3'b010 && iSTATE <= 3'b101;
  // CONV2 and FCL1 (odd codes) live in the upper region
  assign mapBase = iSTATE[0] ? 9'(MEM1_OFFSET) : 9'd0;
  assign mapCount = iSTATE == 3'b010 ? 9'd252 : iSTATE == 3'b011 ? 9'd48 :
                    iSTATE == 3'b100 ? 9'd112 : 9'd12;
  // a state change in S_WRITE aborts, so it must also block the word
  assign accept = state == S_WRITE && iSTATE == stQ && iEN && iVALID;
  always_comb begin
    nState = state;
    nStQ = stQ;
    nBase = base;
    nCount = count;
    nCnt = cnt;
    nWe = accept;
    nAddr = accept ? base + cnt : oADDR;
    nData = accept ? iDATA : oDATA;
    nDonePend = 1'b0;
    case (state)
      S_IDLE:
        if (iEN && isWr) begin
          nState = S_WRITE;
          nStQ = iSTATE;
          nBase = mapBase;
          nCount = mapCount;
          nCnt = 9'd0;
        end
      S_WRITE:
        if (iSTATE != stQ) begin
          nState = S_IDLE;
          nCnt = 9'd0;
        end else if (accept) begin
          nCnt = cnt + 9'd1;
          if (cnt == count - 9'd1) begin
            nState = S_DONE;
            nDonePend = 1'b1;
          end
        end
      S_DONE:
        if (!iEN || iSTATE != stQ) nState = S_IDLE;
      default: nState = S_IDLE;
    endcase
  end
  // oDONE trails the final oWE by one cycle, so MEM1 already holds the word
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= S_IDLE;
      stQ <= 3'd0;
      base <= 9'd0;
      count <= 9'd0;
      cnt <= 9'd0;
      oADDR <= 9'd0;
      oDATA <= '0;
      oWE <= 1'b0;
      donePend <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      state <= nState;
      stQ <= nStQ;
      base <= nBase;
      count <= nCount;
      cnt <= nCnt;
      oADDR <= nAddr;
      oDATA <= nData;
      oWE <= nWe;
      donePend <= nDonePend;
      oDONE <= donePend;
    end
  end
endmodule

// File: tb/tb_mem1_write_controller.sv
// tb_mem1_write_controller: randomized directed bench for mem1_write_controller against a layer-level model
module tb_mem1_write_controller;
  logic iCLK = 1'b0, iRSTn = 1'b0, iEN = 1'b0, iVALID = 1'b0;
  logic [2:0] iSTATE = 3'b000;
  logic [31:0] iDATA = '0;
  logic [8:0] oADDR;
  logic [31:0] oDATA;
  logic oWE, oDONE;
  int checks = 0, errors = 0, weSeen = 0, doneSeen = 0;
  bit mActive = 0, mFinished = 0, mPend = 0;
  logic [2:0] mLayer = 0;
  int mWritten = 0;
  logic expWe = 0, expDone = 0;
  logic [8:0] expAddr = 0;
  logic [31:0] expData = 0;

  mem1_write_controller #(.DATA_WIDTH(32), .MEM1_OFFSET(252)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iSTATE(iSTATE), .iVALID(iVALID),
    .iDATA(iDATA), .oADDR(oADDR), .oDATA(oDATA), .oWE(oWE), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  function automatic int layerBase(input logic [2:0] s);
    return (s == 3'b011 || s == 3'b101) ? 252 : 0;
  endfunction

  function automatic int layerWords(input logic [2:0] s);
    case (s)
      3'b010: return 14 * 18;
      3'b011: return 6 * 8;
      3'b100: return 112;
      default: return 12;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mFinished = 0; mPend = 0; mWritten = 0;
    expWe = 0; expDone = 0; expAddr = 0; expData = 0;
  endtask

  task automatic step(input logic en, input logic [2:0] st, input logic v, input logic [31:0] d);
    iEN = en; iSTATE = st; iVALID = v; iDATA = d;
    @(posedge iCLK);
    #1;
    expDone = mPend;
    mPend = 0;
    expWe = 0;
    if (mActive) begin
      if (st != mLayer) begin
        mActive = 0;
      end else if (en && v) begin
        expWe = 1;
        expAddr = 9'(layerBase(mLayer) + mWritten);
        expData = d;
        mWritten++;
        if (mWritten == layerWords(mLayer)) begin
          mActive = 0; mFinished = 1; mPend = 1;
        end
      end
    end else if (mFinished) begin
      if (!en || st != mLayer) mFinished = 0;
    end else if (en && st >= 3'b010 && st <= 3'b101) begin
      mActive = 1; mLayer = st; mWritten = 0;
    end
    chk("oWE", 32'(oWE), 32'(expWe));
    chk("oDONE", 32'(oDONE), 32'(expDone));
    chk("oADDR", 32'(oADDR), 32'(expAddr));
    chk("oDATA", oDATA, expData);
    if (oWE) weSeen++;
    if (oDONE) doneSeen++;
    @(negedge iCLK);
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_oWE"}, 32'(oWE), 32'd0);
    chk({tag, "_oDONE"}, 32'(oDONE), 32'd0);
    chk({tag, "_oADDR"}, 32'(oADDR), 32'd0);
    chk({tag, "_oDATA"}, oDATA, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge iCLK);
    chkZero("reset");
    iRSTn = 1'b1;
    modelReset();
    // CONV1 interrupted by reset after 100 writes
    step(1, 3'b010, 1, $urandom);
    for (int k = 0; k < 100; k++) step(1, 3'b010, 1, $urandom);
    iRSTn = 1'b0;
    #1;
    chkZero("midreset");
    @(negedge iCLK);
    iRSTn = 1'b1;
    modelReset();
    step(0, 3'b000, 0, 0);
    // CONV1 full layer, iDATA = k
    weSeen = 0; doneSeen = 0;
    step(1, 3'b010, 0, 0);
    for (int k = 0; k < 252; k++) step(1, 3'b010, 1, 32'(k));
    step(1, 3'b010, 0, 0);
    step(1, 3'b010, 1, 32'hdead);
    chk("conv1_writes", 32'(weSeen), 32'd252);
    chk("conv1_done", 32'(doneSeen), 32'd1);
    // back-to-back into CONV2 with bubbles and an iEN drop
    weSeen = 0; doneSeen = 0;
    for (int i = 0; i < 400 && doneSeen == 0; i++)
      step(!(i >= 20 && i < 25), 3'b011, 1'($urandom), $urandom);
    chk("conv2_writes", 32'(weSeen), 32'd48);
    chk("conv2_done", 32'(doneSeen), 32'd1);
    step(0, 3'b011, 0, 0);
    // FCL1 then extra iVALID while held; last word collides with iEN falling once
    weSeen = 0; doneSeen = 0;
    step(1, 3'b101, 1, $urandom);
    for (int k = 0; k < 11; k++) step(1, 3'b101, 1, $urandom);
    step(0, 3'b101, 1, $urandom);
    step(1, 3'b101, 1, $urandom);
    for (int k = 0; k < 10; k++) step(1, 3'b101, 1, $urandom);
    chk("fcl1_writes", 32'(weSeen), 32'd12);
    chk("fcl1_done", 32'(doneSeen), 32'd1);
    step(0, 3'b101, 0, 0);
    // CONV3 aborted after 50 words, FCL1 restarts at its base
    weSeen = 0; doneSeen = 0;
    step(1, 3'b100, 0, 0);
    for (int k = 0; k < 50; k++) step(1, 3'b100, 1, $urandom);
    step(1, 3'b101, 1, $urandom);
    chk("abort_done", 32'(doneSeen), 32'd0);
    step(1, 3'b101, 0, 0);
    step(1, 3'b101, 1, 32'h1234_5678);
    chk("abort_restart_addr", 32'(oADDR), 32'd252);
    for (int k = 0; k < 13; k++) step(1, 3'b101, 1, $urandom);
    chk("abort_writes", 32'(weSeen), 32'd62);
    chk("abort_fcl1_done", 32'(doneSeen), 32'd1);
    step(0, 3'b000, 0, 0);
    // non-writing states
    weSeen = 0; doneSeen = 0;
    for (int i = 0; i < 100; i++) begin
      logic [2:0] s;
      s = (i % 3 == 0) ? 3'b000 : (i % 3 == 1) ? 3'b001 : 3'b110;
      step(1, s, 1'(i), $urandom);
    end
    chk("idle_writes", 32'(weSeen), 32'd0);
    chk("idle_done", 32'(doneSeen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem1_write_controller.md
# mem1_write_controller

Write-side address generator and write strobe for the MEM1 activation buffer in the BNN datapath. It accepts the serial output words of the active layer (CONV1, CONV2, CONV3, FCL1) and writes them into MEM1 at the base address and word count that the next layer's read controller expects. It signals layer-write completion to the top-level sequencer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one MEM1 word.
- MEM1_OFFSET, 252, base address of the upper MEM1 region.

Ports:
- iCLK  in  1  system clock; all logic on the rising edge.
- iRSTn  in  1  reset; asynchronous, active-low.
- iEN  in  1  write enable from the sequencer; high for the whole layer.
- iSTATE  in  3  layer state: IDLE 000, READ 001, CONV1 010, CONV2 011, CONV3 100, FCL1 101, FCL2 110.
- iVALID  in  1  one output word is present on iDATA this cycle.
- iDATA  in  DATA_WIDTH  output word from the layer engine.
- oADDR  out  9  MEM1 write address, registered.
- oDATA  out  DATA_WIDTH  MEM1 write data, registered.
- oWE  out  1  MEM1 write strobe, registered.
- oDONE  out  1  one-cycle pulse when the layer's last word has been written.

## Operation
Layer map (base, word count):
- CONV1: 0, 252 (14×18).
- CONV2: MEM1_OFFSET, 48 (6×8).
- CONV3: 0, 112.
- FCL1: MEM1_OFFSET, 12.
- IDLE, READ and FCL2 are non-writing states. The block stays in S_IDLE for them and never asserts oWE.

FSM states:
- **S_IDLE**
  - If iEN=1 and iSTATE is a writing state: latch iSTATE into st_q, load base and count from the layer map, clear cnt, go to S_WRITE.
  - iVALID is ignored in this state.
- **S_WRITE**
  - When iEN=1 and iVALID=1: next cycle oWE=1, oADDR=base+cnt, oDATA=iDATA, and cnt increments.
  - When the accepted word has cnt==count-1: go to S_DONE.
  - iEN=0: the FSM pauses. iVALID is ignored, cnt is held, and oWE=0.
  - iSTATE≠st_q: abort to S_IDLE with cnt cleared, no oDONE, and no write for that cycle's iVALID.
- **S_DONE**
  - oDONE=1 only in the first cycle in this state.
  - Stay here while iEN=1, ignoring iVALID.
  - Go to S_IDLE when iEN=0 or iSTATE≠st_q.

Arithmetic and widths:
- cnt is 9 bits.
- base+cnt is a 9-bit add with no overflow, since the maximum is 252+47=299.
- oADDR must never exceed base+count-1.

## Timing
- **Reset values:** oADDR=0, oDATA=0, oWE=0, oDONE=0, FSM=S_IDLE, cnt=0.
- **Reset mid-operation:** reset takes effect immediately. The partial layer is discarded and no oDONE is produced.
- **Write latency:** 1 cycle from iVALID to oWE/oADDR/oDATA. With iVALID high continuously, one write is issued every cycle.
- **Entry latency:** if iEN rises with iSTATE valid at edge N, the FSM is in S_WRITE after edge N. The earliest accepted iVALID is sampled at edge N+1.
- **Completion:** if the last word's iVALID is sampled at edge M, then oWE is high in cycle M..M+1 and oDONE is high in cycle M+1..M+2. That is one cycle after the final oWE, so MEM1 is already updated when oDONE is seen.
- **Between strobes:** oWE and oDONE are 0 in every cycle not described above. oADDR and oDATA hold their last value when oWE=0.
- **Simultaneous events:**
  - iSTATE change together with iVALID in S_WRITE: the abort wins.
  - iEN falling together with the last iVALID: the word is not accepted, because iEN gates acceptance.
- **Back-to-back layers:** when iSTATE advances (e.g. CONV1→CONV2) while iEN stays 1:
  - S_DONE→S_IDLE on the first cycle of the new state.
  - S_IDLE→S_WRITE on the next cycle.
  - So 2 cycles of latency before the first new iVALID is accepted.

## Test plan
- **Reset:** assert iRSTn=0 mid-CONV1 after 100 writes → all outputs 0 within the same cycle. After release and re-entry, the first write has oADDR=0.
- **CONV1 full layer:** iSTATE=010, iEN=1, 252 consecutive iVALID with iDATA=k → 252 oWE pulses with oADDR=0..251 and oDATA=k. A single oDONE one cycle after the oADDR=251 write.
- **CONV2 with gaps:** iSTATE=011, 48 iVALID with random bubbles and iEN dropped for 5 cycles mid-layer → oADDR=252..299 in order, no writes while iEN=0, one oDONE.
- **FCL1 then hold:** iSTATE=101, 12 words → oADDR=252..263 and oDONE. 10 further iVALID while iEN=1 → no oWE, no second oDONE.
- **Abort:** iSTATE=100, 50 words accepted, then iSTATE switched to 101 → no oDONE. The FCL1 layer then starts at oADDR=252 with cnt reset.
- **Non-writing states:** iSTATE=000/001/110 with iEN=1 and iVALID toggling for 100 cycles → oWE=0 and oDONE=0 throughout.
